// File: rtl/sprite_pos_ctrl.sv
// sprite_pos_ctrl: debounced up/down buttons step obj_y by at most one STEP per frame.
// Define HOLD_REPEAT_EN to auto-repeat a held button every frame after REPEAT_DELAY frames.
module sprite_pos_ctrl #(
   parameter int DEBOUNCE_CYCLES = 148500,
   parameter int V_ACTIVE        = 1080,
   parameter int OBJ_H           = 64,
   parameter int STEP            = 4,
   parameter int Y_INIT          = 508,
   parameter int REPEAT_DELAY    = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btnU,
   input  logic        btnD,
   input  logic        frame_start,
   output logic [10:0] obj_y,
   output logic        pos_update,
   output logic        at_top,
   output logic        at_bottom
);
   localparam int Y_MAX = V_ACTIVE - OBJ_H;
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   typedef enum logic {IDLE, APPLY} state_t;
   state_t state;
   logic [1:0] s1, s2, db, pend, press, rep;
   logic [CW-1:0] cnt [2];
   logic [11:0] y_dn, y_up;
   logic [10:0] y_nx;
   // bit 0 is the up button, bit 1 the down button
   always_comb begin
      for (int i = 0; i < 2; i++)
         press[i] = s2[i] && !db[i] && cnt[i] == CW'(DEBOUNCE_CYCLES - 1);
      y_dn = {1'b0, obj_y} - 12'(STEP);
      y_up = {1'b0, obj_y} + 12'(STEP);
      y_nx = pend == 2'b01 ? (y_dn[11] ? 11'd0 : y_dn[10:0]) :
             pend == 2'b10 ? (y_up > 12'(Y_MAX) ? 11'(Y_MAX) : y_up[10:0]) : obj_y;
   end
   assign at_top = obj_y == 11'd0;
   assign at_bottom = obj_y == 11'(Y_MAX);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
         db <= '0;
         pend <= '0;
         cnt[0] <= '0;
         cnt[1] <= '0;
         obj_y <= 11'(Y_INIT);
         pos_update <= 1'b0;
         state <= IDLE;
      end else begin
         s1 <= {btnD, btnU};
         s2 <= s1;
         for (int i = 0; i < 2; i++) begin
            cnt[i] <= (s2[i] == db[i] || cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt[i] + CW'(1);
            if (s2[i] != db[i] && cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) db[i] <= s2[i];
         end
         pend <= (state == APPLY ? 2'b00 : pend) | press | rep;
         pos_update <= state == APPLY && y_nx != obj_y;
         if (state == APPLY) obj_y <= y_nx;
         state <= (state == IDLE && frame_start) ? APPLY : IDLE;
      end
`ifdef HOLD_REPEAT_EN
   localparam int RW = $clog2(REPEAT_DELAY + 1);
   logic [RW-1:0] fcnt [2];
   always_comb
      for (int i = 0; i < 2; i++)
         rep[i] = frame_start && state == IDLE && db[i] && fcnt[i] == RW'(REPEAT_DELAY);
   // counter saturates at REPEAT_DELAY so every later frame repeats
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         fcnt[0] <= '0;
         fcnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++)
            if (!db[i]) fcnt[i] <= '0;
            else if (frame_start && state == IDLE && fcnt[i] != RW'(REPEAT_DELAY)) fcnt[i] <= fcnt[i] + RW'(1);
      end
`else
   assign rep = 2'b00;
`endif
endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// tb_sprite_pos_ctrl: table-driven and scoreboard checks of two instances (Y_INIT 508 and 2).
module tb_sprite_pos_ctrl;
   logic clk = 0, reset = 1, btnU = 0, btnD = 0, frame_start = 0;
   logic [10:0] ya_o, yb_o;
   logic pua, pub, ta, tb, ba, bb;
   int n_cmp = 0, n_bad = 0;
   int ya = 508, yb = 2;
   typedef struct {int ea; bit pa; int eb; bit pb;} exp_t;
   typedef struct {bit u; bit d; int hold; int ea; bit pa;} vec_t;
   exp_t sb[$];
   vec_t vt[7];
   int t6[6];

   always #5 clk = ~clk;

   sprite_pos_ctrl #(.DEBOUNCE_CYCLES(4), .V_ACTIVE(1080), .OBJ_H(64), .STEP(4), .Y_INIT(508), .REPEAT_DELAY(3))
   dut_a (.clk(clk), .reset(reset), .btnU(btnU), .btnD(btnD), .frame_start(frame_start),
          .obj_y(ya_o), .pos_update(pua), .at_top(ta), .at_bottom(ba));
   sprite_pos_ctrl #(.DEBOUNCE_CYCLES(4), .V_ACTIVE(1080), .OBJ_H(64), .STEP(4), .Y_INIT(2), .REPEAT_DELAY(3))
   dut_b (.clk(clk), .reset(reset), .btnU(btnU), .btnD(btnD), .frame_start(frame_start),
          .obj_y(yb_o), .pos_update(pub), .at_top(tb), .at_bottom(bb));

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int mv(input int y, input bit u, input bit d, input int hold);
      if (hold < 4 || u == d) return y;
      if (u) return y < 4 ? 0 : y - 4;
      return y + 4 > 1016 ? 1016 : y + 4;
   endfunction

   task automatic press(input bit u, input bit d, input int hold);
      if (hold > 0) begin
         @(negedge clk);
         btnU = u;
         btnD = d;
         repeat (hold) @(negedge clk);
         btnU = 0;
         btnD = 0;
         repeat (10) @(negedge clk);
      end
   endtask

   task automatic frame(input int ea, input bit pa, input int eb, input bit pb);
      exp_t e;
      @(negedge clk);
      frame_start = 1;
      sb.push_back('{ea, pa, eb, pb});
      @(negedge clk);
      frame_start = 0;
      chk("early_a", ya_o, ya);
      chk("early_b", yb_o, yb);
      @(negedge clk);
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard: got empty queue expected entry");
      end else begin
         e = sb.pop_front();
         chk("obj_y_a", ya_o, e.ea);
         chk("pos_update_a", pua, e.pa);
         chk("at_top_a", ta, e.ea == 0);
         chk("at_bottom_a", ba, e.ea == 1016);
         chk("obj_y_b", yb_o, e.eb);
         chk("pos_update_b", pub, e.pb);
         chk("at_top_b", tb, e.eb == 0);
         chk("at_bottom_b", bb, e.eb == 1016);
      end
      @(negedge clk);
      chk("pulse_a", pua, 0);
      chk("pulse_b", pub, 0);
      ya = ea;
      yb = eb;
   endtask

   task automatic step(input bit u, input bit d, input int hold, input int ea, input bit pa);
      int eb;
      press(u, d, hold);
      eb = mv(yb, u, d, hold);
      frame(ea, pa, eb, eb != yb);
   endtask

   task automatic mstep(input bit u, input bit d, input int hold);
      int ea;
      ea = mv(ya, u, d, hold);
      step(u, d, hold, ea, ea != ya);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      ya = 508;
      yb = 2;
   endtask

   initial begin
      vt[0] = '{1, 0, 10, 504, 1};
      vt[1] = '{0, 1, 10, 508, 1};
      vt[2] = '{0, 1, 3, 508, 0};
      vt[3] = '{1, 1, 10, 508, 0};
      vt[4] = '{0, 0, 0, 508, 0};
      vt[5] = '{0, 1, 10, 512, 1};
      vt[6] = '{1, 0, 10, 508, 1};
`ifdef HOLD_REPEAT_EN
      t6 = '{512, 512, 512, 516, 520, 524};
`else
      t6 = '{512, 512, 512, 512, 512, 512};
`endif
      repeat (3) @(negedge clk);
      chk("reset_y_a", ya_o, 508);
      chk("reset_y_b", yb_o, 2);
      chk("reset_pu_a", pua, 0);
      chk("reset_top_b", tb, 0);
      chk("reset_bot_a", ba, 0);
      reset = 0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 7; i++) step(vt[i].u, vt[i].d, vt[i].hold, vt[i].ea, vt[i].pa);
      // async reset while a step is pending and a debounce is in progress
      mstep(0, 1, 10);
      press(1, 0, 10);
      @(negedge clk);
      btnD = 1;
      repeat (2) @(negedge clk);
      #2 reset = 1;
      #1;
      chk("async_y_a", ya_o, 508);
      chk("async_y_b", yb_o, 2);
      btnD = 0;
      @(negedge clk);
      reset = 0;
      ya = 508;
      yb = 2;
      repeat (10) @(negedge clk);
      frame(508, 0, 2, 0);
      // held down button across six frames
      @(negedge clk);
      btnD = 1;
      repeat (10) @(negedge clk);
      for (int k = 0; k < 6; k++) frame(t6[k], t6[k] != ya, t6[k] - 506, t6[k] != ya);
      btnD = 0;
      repeat (10) @(negedge clk);
      // walk to the bottom edge: instance b passes 1014 then clamps at 1016
      do_reset();
      for (int k = 0; k < 253; k++) mstep(0, 1, 10);
      chk("edge_b_1014", yb, 1014);
      mstep(0, 1, 10);
      mstep(0, 1, 10);
      do_reset();
      mstep(1, 0, 10);
      mstep(1, 0, 10);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
